// File: rtl/ifetch_stage.sv
// ---------------------------------------------------------------------------
// ifetch_stage
//   Instruction-fetch stage of the five-stage RISC-V pipeline. Owns the fetch
//   PC, addresses a synchronous instruction ROM with a one-cycle read latency,
//   and holds the IF/ID pipeline register consumed by decode.
//
//   Update priority on each rising edge: flush > stall > normal advance.
//   A flush restarts fetch at redirect_pc (word aligned) and squashes both the
//   ROM read in flight and the IF/ID contents, so two bubbles reach decode.
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   stall        hold PC, in-flight read and IF/ID register this cycle
//   flush        redirect fetch and squash in-flight / IF/ID contents
//   redirect_pc  redirect target, sampled when flush = 1
//   irom_addr    IROM word address (combinational)
//   irom_data    IROM data for the address presented at the previous edge
//   ID_inst      instruction handed to decode (NOP_INST when a bubble)
//   ID_pc        PC of ID_inst
//   ID_pc4       ID_pc + 4
//   ID_valid     ID_inst is a real instruction, not a bubble
// ---------------------------------------------------------------------------
module ifetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 14,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] irom_addr,
  input  logic [31:0]       irom_data,
  output logic [31:0]       ID_inst,
  output logic [31:0]       ID_pc,
  output logic [31:0]       ID_pc4,
  output logic              ID_valid
);

  // Fetch PC and the ROM read currently in flight.
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] pc_d_q, pc_d_d;
  logic        d_valid_q, d_valid_d;

  // IF/ID pipeline register.
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        id_valid_q, id_valid_d;

  // The low two bits of a redirect target are discarded.
  logic [31:0] redirect_aligned;
  assign redirect_aligned = redirect_pc & ~32'h0000_0003;

  // Next-state logic.
  // NOTE: every signal is given a default (its current value) before the
  // branches, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pc_f_d     = pc_f_q;
    pc_d_d     = pc_d_q;
    d_valid_d  = d_valid_q;
    id_inst_d  = id_inst_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    id_valid_d = id_valid_q;

    if (flush) begin
      // ID_pc / ID_pc4 intentionally hold; only validity and the word change.
      pc_f_d     = redirect_aligned;
      d_valid_d  = 1'b0;
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
    end else if (!stall) begin
      pc_f_d     = pc_f_q + 32'd4;
      pc_d_d     = pc_f_q;
      d_valid_d  = 1'b1;
      id_inst_d  = d_valid_q ? irom_data : NOP_INST;
      id_pc_d    = pc_d_q;
      id_pc4_d   = pc_d_q + 32'd4;
      id_valid_d = d_valid_q;
    end
  end

  // State registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f_q     <= RESET_PC;
      pc_d_q     <= 32'd0;
      d_valid_q  <= 1'b0;
      id_inst_q  <= NOP_INST;
      id_pc_q    <= 32'd0;
      id_pc4_q   <= 32'd0;
      id_valid_q <= 1'b0;
    end else begin
      pc_f_q     <= pc_f_d;
      pc_d_q     <= pc_d_d;
      d_valid_q  <= d_valid_d;
      id_inst_q  <= id_inst_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      id_valid_q <= id_valid_d;
    end
  end

  // IROM address. During a stall the in-flight address is replayed so the
  // ROM output register keeps presenting mem[pc_d] and nothing is lost when
  // the stall releases. While reset is held the reset PC is presented even
  // if stall happens to be asserted.
  always_comb begin
    irom_addr = pc_f_q[ADDR_W+1:2];
    if (!rst_n) begin
      irom_addr = RESET_PC[ADDR_W+1:2];
    end else if (stall && !flush) begin
      irom_addr = pc_d_q[ADDR_W+1:2];
    end
  end

  assign ID_inst  = id_inst_q;
  assign ID_pc    = id_pc_q;
  assign ID_pc4   = id_pc4_q;
  assign ID_valid = id_valid_q;

endmodule

// File: tb/tb_ifetch_stage.sv
// ---------------------------------------------------------------------------
// tb_ifetch_stage
//   Self-checking bench for ifetch_stage. A synchronous ROM whose word k holds
//   0x1000 + k feeds the DUT. The reference model tracks only which PC sits
//   in each pipeline slot; the expected instruction is computed from that PC
//   directly, so an addressing or replay error in the DUT shows up as a wrong
//   word in ID_inst.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ifetch_stage;

  localparam int          ADDR_W   = 14;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall;
  logic              flush;
  logic [31:0]       redirect_pc;
  logic [ADDR_W-1:0] irom_addr;
  logic [31:0]       irom_data = 32'd0;
  logic [31:0]       ID_inst;
  logic [31:0]       ID_pc;
  logic [31:0]       ID_pc4;
  logic              ID_valid;

  int vectors = 0;
  int miscompares = 0;

  ifetch_stage #(
    .RESET_PC (RESET_PC),
    .ADDR_W   (ADDR_W),
    .NOP_INST (NOP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .irom_addr   (irom_addr),
    .irom_data   (irom_data),
    .ID_inst     (ID_inst),
    .ID_pc       (ID_pc),
    .ID_pc4      (ID_pc4),
    .ID_valid    (ID_valid)
  );

  always #5 clk = ~clk;

  // ROM contents as a function of the byte PC: only word-address bits count.
  function automatic logic [31:0] rom_at_pc(input logic [31:0] pc);
    logic [ADDR_W-1:0] w;
    w = pc[ADDR_W+1:2];
    return 32'h0000_1000 + 32'(w);
  endfunction

  // Synchronous ROM with one-cycle read latency.
  always @(posedge clk) irom_data <= 32'h0000_1000 + 32'(irom_addr);

  // ---------------- reference model ----------------
  // A slot is "the instruction at address pc, present or not".
  typedef struct {
    bit          valid;
    logic [31:0] pc;
  } slot_t;

  logic [31:0] m_next_fetch;   // next address to be fetched
  slot_t       m_read;         // read issued, data not yet in decode
  slot_t       m_dec;          // what decode currently holds
  logic [31:0] m_dec_pc4;

  function automatic void model_reset();
    m_next_fetch = RESET_PC;
    m_read       = '{valid: 1'b0, pc: 32'd0};
    m_dec        = '{valid: 1'b0, pc: 32'd0};
    m_dec_pc4    = 32'd0;
  endfunction

  function automatic void model_edge(input bit s, input bit f, input logic [31:0] r);
    if (f) begin
      m_next_fetch = {r[31:2], 2'b00};
      m_read.valid = 1'b0;
      m_dec.valid  = 1'b0;
    end else if (!s) begin
      m_dec        = m_read;
      m_dec_pc4    = m_read.pc + 32'd4;
      m_read       = '{valid: 1'b1, pc: m_next_fetch};
      m_next_fetch = m_next_fetch + 32'd4;
    end
  endfunction

  function automatic logic [31:0] exp_inst();
    return m_dec.valid ? rom_at_pc(m_dec.pc) : NOP;
  endfunction

  function automatic logic [ADDR_W-1:0] exp_addr(input bit s, input bit f);
    logic [31:0] a;
    a = (s && !f) ? m_read.pc : m_next_fetch;
    return a[ADDR_W+1:2];
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 32'(ID_valid), 32'(m_dec.valid));
    check({tag, ".inst"},  ID_inst, exp_inst());
    check({tag, ".pc"},    ID_pc,   m_dec.pc);
    check({tag, ".pc4"},   ID_pc4,  m_dec_pc4);
  endtask

  // One clock: drive inputs just after the falling edge, check the
  // combinational address, take the rising edge, compare at the falling edge.
  task automatic cycle(input bit s, input bit f, input logic [31:0] r, input string tag);
    stall = s;
    flush = f;
    redirect_pc = r;
    #1;
    check({tag, ".addr"}, 32'(irom_addr), 32'(exp_addr(s, f)));
    @(posedge clk);
    model_edge(s, f, r);
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    logic [31:0] r;
    bit s, f;

    // ---- reset ----
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    check("reset.addr", 32'(irom_addr), 32'(RESET_PC[ADDR_W+1:2]));
    rst_n = 1'b1;

    // ---- straight-line fetch ----
    cycle(0, 0, 0, "boot1");
    check("boot1.bubble", 32'(ID_valid), 32'd0);
    cycle(0, 0, 0, "boot2");
    check("boot2.inst", ID_inst, 32'h1000);
    check("boot2.pc",   ID_pc,   32'h0);
    cycle(0, 0, 0, "seq1");
    check("seq1.inst", ID_inst, 32'h1001);
    cycle(0, 0, 0, "seq2");
    check("seq2.pc", ID_pc, 32'h8);

    // ---- three-cycle stall at ID_pc = 8 ----
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, "stall");
      check("stall.hold_inst", ID_inst, 32'h1002);
    end
    cycle(0, 0, 0, "unstall1");
    check("unstall1.pc", ID_pc, 32'd12);
    check("unstall1.inst", ID_inst, 32'h1003);
    cycle(0, 0, 0, "unstall2");
    check("unstall2.pc", ID_pc, 32'd16);

    // ---- redirect to 0x40 ----
    cycle(0, 1, 32'h40, "flush40a");
    check("flush40a.inst", ID_inst, NOP);
    cycle(0, 0, 0, "flush40b");
    check("flush40b.valid", 32'(ID_valid), 32'd0);
    cycle(0, 0, 0, "flush40c");
    check("flush40c.pc", ID_pc, 32'h40);
    check("flush40c.inst", ID_inst, 32'h1010);

    // ---- flush and stall together, unaligned target ----
    cycle(1, 1, 32'h23, "fs_a");
    cycle(0, 0, 0, "fs_b");
    cycle(0, 0, 0, "fs_c");
    check("fs_c.pc", ID_pc, 32'h20);
    check("fs_c.inst", ID_inst, 32'h1008);

    // ---- reset asserted mid-stall ----
    cycle(1, 0, 0, "prerst");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("midrst");
    check("midrst.addr", 32'(irom_addr), 32'(RESET_PC[ADDR_W+1:2]));
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 0, 0, "rboot1");
    cycle(0, 0, 0, "rboot2");
    check("rboot2.inst", ID_inst, 32'h1000);

    // ---- wrap-around at the top of the address space ----
    cycle(0, 1, 32'hFFFF_FFFC, "wrap_a");
    cycle(0, 0, 0, "wrap_b");
    cycle(0, 0, 0, "wrap_c");
    check("wrap_c.pc",  ID_pc,  32'hFFFF_FFFC);
    check("wrap_c.pc4", ID_pc4, 32'h0000_0000);
    cycle(0, 0, 0, "wrap_d");
    check("wrap_d.pc", ID_pc, 32'h0000_0000);

    // ---- randomized traffic ----
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 99) < 25);
      f = ($urandom_range(0, 99) < 8);
      case ($urandom_range(0, 3))
        0:       r = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
        1:       r = 32'($urandom_range(0, 255));
        default: r = $urandom;
      endcase
      cycle(s, f, r, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifetch_stage.md
# ifetch_stage

Instruction-fetch stage of the five-stage pipelined RISC-V core: the producer end of the ID stage's `ID_inst` interface. It owns the fetch PC, drives a synchronous instruction ROM (one-cycle read latency), and maintains the IF/ID pipeline register (`ID_inst`, `ID_pc`, `ID_pc4`, `ID_valid`) consumed by decode. It honours `stall` from hazard detection and `flush`/`redirect_pc` from branch/jump resolution, inserting NOP bubbles on redirect.

## Interface

Parameters:
- `RESET_PC`, 32'h0000_0000, fetch address after reset
- `ADDR_W`, 14, IROM word-address width
- `NOP_INST`, 32'h0000_0013, bubble encoding (`addi x0,x0,0`)

Ports:
- `clk`  input  1  sole clock, rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `stall`  input  1  hold PC and IF/ID register this cycle
- `flush`  input  1  redirect fetch; squash in-flight and IF/ID contents
- `redirect_pc`  input  32  target PC, sampled when `flush`=1
- `irom_addr`  output  ADDR_W  IROM word address (combinational)
- `irom_data`  input  32  IROM data for the address latched at the previous edge
- `ID_inst`  output  32  instruction to decode
- `ID_pc`  output  32  PC of `ID_inst`
- `ID_pc4`  output  32  `ID_pc + 4`
- `ID_valid`  output  1  `ID_inst` is a real instruction, not a bubble

## Operation

Internal state:
- `pc_f` (32): address being presented to IROM
- `pc_d` (32), `d_valid` (1): PC and validity of the IROM read in flight
- IF/ID register: `ID_inst`, `ID_pc`, `ID_pc4`, `ID_valid`

Per-edge update, priority flush > stall > normal:
- flush: `pc_f <= {redirect_pc[31:2],2'b00}`; `d_valid <= 0`; `ID_inst <= NOP_INST`, `ID_valid <= 0`, `ID_pc`/`ID_pc4` hold.
- stall (no flush): `pc_f`, `pc_d`, `d_valid`, IF/ID all hold.
- normal: `pc_f <= pc_f + 4`; `pc_d <= pc_f`; `d_valid <= 1`; `ID_inst <= d_valid ? irom_data : NOP_INST`; `ID_pc <= pc_d`; `ID_pc4 <= pc_d + 4`; `ID_valid <= d_valid`.

IROM address (combinational):
- `irom_addr = stall && !flush ? pc_d[ADDR_W+1:2] : pc_f[ADDR_W+1:2]`.
- Replaying `pc_d` during stall keeps `irom_data == mem[pc_d]` across the stall, so no data is lost.

Arithmetic:
- All PC adds are 32-bit, modulo 2^32; `0xFFFF_FFFC + 4 = 0`.
- PC bits above `ADDR_W+1` are ignored by `irom_addr`.
- `redirect_pc[1:0]` is discarded.

## Timing

- Reset (async assert, any time, including mid-stall/flush):
  - `pc_f = RESET_PC`, `pc_d = 0`, `d_valid = 0`.
  - `ID_inst = NOP_INST`, `ID_pc = 0`, `ID_pc4 = 0`, `ID_valid = 0`.
  - `irom_addr = RESET_PC[ADDR_W+1:2]` while reset is held.
- Latency: an address in `pc_f` at edge N appears in `ID_inst` after edge N+1 (two edges from presentation). The first valid instruction after reset deassertion appears after the second rising edge.
- Redirect penalty: `flush` at edge E gives `ID_valid = 0` after E and E+1, and `mem[target]` in `ID_inst` after E+2.
- Steady state: one instruction per cycle; `ID_pc` increments by 4 each non-stalled cycle.
- `stall` while `d_valid = 0`: everything holds; the bubble persists.
- `stall` and `flush` together: flush wins; stall is ignored that cycle.
- Back-to-back flushes: each restarts from the newest `redirect_pc`.

## Test plan

- Reset then straight-line fetch, ROM word *k* = 0x1000+k: release `rst_n` → `ID_valid` rises after the 2nd edge with `ID_inst` = 0x1000, `ID_pc` = 0; then 0x1001/4, 0x1002/8 on consecutive cycles.
- `stall` high 3 cycles while `ID_pc` = 8: `ID_inst`/`ID_pc` hold at word2/8 through the stall; after release, `ID_pc` = 12, then 16, with no word skipped or duplicated.
- `flush` with `redirect_pc` = 0x40 while streaming: two cycles of `ID_valid` = 0 with `ID_inst` = 0x13, then `ID_pc` = 0x40 and `ID_inst` = word16.
- `flush` and `stall` in the same cycle with `redirect_pc` = 0x23 → behaves as flush to 0x20; the stall has no effect.
- `rst_n` asserted mid-stall → outputs immediately reach reset values (`ID_valid` = 0, `ID_inst` = 0x13); fetch restarts at `RESET_PC`.
- Redirect to 0xFFFF_FFFC → `ID_pc` = 0xFFFF_FFFC then 0x0000_0000; `ID_pc4` = 0x0000_0000 for the first of these.
